// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell stepped LSB-first over WIDTH bits.
// Result, borrow and zero are registered and update only when done pulses.
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d, borrow_q, borrow_d, zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d_bit, brw_nxt;
  logic [WIDTH-1:0] r_nxt;

  always_comb begin
    d_bit   = a_q[0] ^ b_q[0] ^ brw_q;
    brw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    r_nxt   = {d_bit, r_q[WIDTH-1:1]};

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start directly so back-to-back ops have no gap
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = brw_nxt;
        r_d   = r_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = r_nxt;
          borrow_d = brw_nxt;
          zero_d   = (r_nxt == '0);
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign ready      = (state_q == IDLE) || (state_q == DONE);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign difference = diff_q;
  assign borrow     = borrow_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: a 4-bit and an 8-bit instance sharing clock and reset.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start4, bin4, ready4, busy4, done4, borrow4, zero4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, ready8, busy8, done8, borrow8, zero8;
  logic [7:0] a8, b8, diff8;

  serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .ready(ready4), .busy(busy4), .done(done4), .difference(diff4),
    .borrow(borrow4), .zero(zero4)
  );

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .difference(diff8),
    .borrow(borrow8), .zero(zero8)
  );

  int n_chk = 0;
  int n_pass = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        br;
    logic        z;
    int unsigned acc;
  } sb_t;

  sb_t q4[$];
  sb_t q8[$];
  logic [3:0] last4 = '0;
  logic [7:0] last8 = '0;

  // Reference: (WIDTH+1)-bit unsigned subtraction; sign bit is the borrow.
  function automatic sb_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                input logic bin, input int unsigned acc);
    sb_t e;
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    e.d   = (w == 4) ? {4'b0, t[3:0]} : t[7:0];
    e.br  = t[8];
    e.z   = (e.d == 8'd0);
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      q4.delete();
      last4 = '0;
    end else begin
      chk("busy_done_excl4", {31'b0, busy4 & done4}, 0);
      if (done4) begin
        if (q4.size() == 0) chk("sb4_spurious_done", 1, 0);
        else begin
          e = q4.pop_front();
          chk("sb4_diff", {28'b0, diff4}, {24'b0, e.d});
          chk("sb4_borrow", {31'b0, borrow4}, {31'b0, e.br});
          chk("sb4_zero", {31'b0, zero4}, {31'b0, e.z});
          chk("sb4_latency", cyc - e.acc, 4);
        end
        last4 = diff4;
      end
      if (busy4) chk("sb4_hold_in_run", {28'b0, diff4}, {28'b0, last4});
      if (start4 && ready4) q4.push_back(model(4, {4'b0, a4}, {4'b0, b4}, bin4, cyc + 1));
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      q8.delete();
      last8 = '0;
    end else begin
      chk("busy_done_excl8", {31'b0, busy8 & done8}, 0);
      if (done8) begin
        if (q8.size() == 0) chk("sb8_spurious_done", 1, 0);
        else begin
          e = q8.pop_front();
          chk("sb8_diff", {24'b0, diff8}, {24'b0, e.d});
          chk("sb8_borrow", {31'b0, borrow8}, {31'b0, e.br});
          chk("sb8_zero", {31'b0, zero8}, {31'b0, e.z});
          chk("sb8_latency", cyc - e.acc, 8);
        end
        last8 = diff8;
      end
      if (busy8) chk("sb8_hold_in_run", {24'b0, diff8}, {24'b0, last8});
      if (start8 && ready8) q8.push_back(model(8, a8, b8, bin8, cyc + 1));
    end
  end

  task automatic wait_done4(output logic got, output int nbusy);
    got = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done4) begin
        got = 1'b1;
        break;
      end
      if (busy4) nbusy++;
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                      output logic got, output int nbusy);
    @(posedge clk); #1;
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done4(got, nbusy);
  endtask

  typedef struct {
    logic [3:0] a, b;
    logic       bin;
    logic [3:0] d;
    logic       br, z;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic got;
    int nb, nd;
    int unsigned t1;

    tbl[0] = '{a: 4'd3,  b: 4'd7,  bin: 1'b0, d: 4'hC, br: 1'b1, z: 1'b0};
    tbl[1] = '{a: 4'd5,  b: 4'd5,  bin: 1'b1, d: 4'hF, br: 1'b1, z: 1'b0};
    tbl[2] = '{a: 4'd9,  b: 4'd9,  bin: 1'b0, d: 4'h0, br: 1'b0, z: 1'b1};
    tbl[3] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, d: 4'hF, br: 1'b1, z: 1'b0};
    tbl[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, d: 4'hF, br: 1'b0, z: 1'b0};
    tbl[5] = '{a: 4'd15, b: 4'd15, bin: 1'b1, d: 4'hF, br: 1'b1, z: 1'b0};
    tbl[6] = '{a: 4'd1,  b: 4'd0,  bin: 1'b1, d: 4'h0, br: 1'b0, z: 1'b1};
    tbl[7] = '{a: 4'd12, b: 4'd5,  bin: 1'b1, d: 4'h6, br: 1'b0, z: 1'b0};
    tbl[8] = '{a: 4'd2,  b: 4'd11, bin: 1'b0, d: 4'h7, br: 1'b1, z: 1'b0};

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    #12;
    chk("rst_ready4", {31'b0, ready4}, 1);
    chk("rst_busy4", {31'b0, busy4}, 0);
    chk("rst_done4", {31'b0, done4}, 0);
    chk("rst_diff4", {28'b0, diff4}, 0);
    chk("rst_borrow4", {31'b0, borrow4}, 0);
    chk("rst_zero4", {31'b0, zero4}, 0);
    chk("rst_ready8", {31'b0, ready8}, 1);
    chk("rst_diff8", {24'b0, diff8}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic op: 7 - 3
    run4(4'd7, 4'd3, 1'b0, got, nb);
    chk("t1_done_seen", {31'b0, got}, 1);
    chk("t1_busy_cycles", nb, 4);
    chk("t1_ready_in_done", {31'b0, ready4}, 1);
    chk("t1_busy_in_done", {31'b0, busy4}, 0);
    chk("t1_diff", {28'b0, diff4}, 4);
    chk("t1_borrow", {31'b0, borrow4}, 0);
    chk("t1_zero", {31'b0, zero4}, 0);

    for (int i = 0; i < 9; i++) begin
      run4(tbl[i].a, tbl[i].b, tbl[i].bin, got, nb);
      chk($sformatf("tbl%0d_done", i), {31'b0, got}, 1);
      chk($sformatf("tbl%0d_diff", i), {28'b0, diff4}, {28'b0, tbl[i].d});
      chk($sformatf("tbl%0d_borrow", i), {31'b0, borrow4}, {31'b0, tbl[i].br});
      chk($sformatf("tbl%0d_zero", i), {31'b0, zero4}, {31'b0, tbl[i].z});
    end

    // Start held; operands change during RUN; restart in the DONE cycle
    @(posedge clk); #1;
    a4 = 4'd8; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'd2; b4 = 4'd3;
    wait_done4(got, nb);
    chk("t3_first_done", {31'b0, got}, 1);
    chk("t3_first_diff", {28'b0, diff4}, 7);
    chk("t3_first_borrow", {31'b0, borrow4}, 0);
    t1 = cyc;
    @(negedge clk);
    chk("t3_no_gap_busy", {31'b0, busy4}, 1);
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done4(got, nb);
    chk("t3_second_done", {31'b0, got}, 1);
    chk("t3_second_latency", cyc - (t1 + 1), 4);
    chk("t3_second_diff", {28'b0, diff4}, 15);
    chk("t3_second_borrow", {31'b0, borrow4}, 1);

    // Async reset in the middle of RUN
    @(posedge clk); #1;
    a4 = 4'd6; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t4_rst_ready", {31'b0, ready4}, 1);
    chk("t4_rst_busy", {31'b0, busy4}, 0);
    chk("t4_rst_done", {31'b0, done4}, 0);
    chk("t4_rst_diff", {28'b0, diff4}, 0);
    chk("t4_rst_borrow", {31'b0, borrow4}, 0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) nd++;
    end
    chk("t4_no_done_after_rst", nd, 0);
    chk("t4_ready_after_rst", {31'b0, ready4}, 1);
    run4(4'd6, 4'd2, 1'b0, got, nb);
    chk("t4_fresh_done", {31'b0, got}, 1);
    chk("t4_fresh_diff", {28'b0, diff4}, 4);
    chk("t4_fresh_borrow", {31'b0, borrow4}, 0);

    // 8-bit: directed boundaries then random, mixing back-to-back and idle gaps
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; end
      else if (i == 1) begin a8 = 8'h00; b8 = 8'h00; bin8 = 1'b1; end
      else if (i == 2) begin a8 = 8'd77; b8 = 8'd77; bin8 = 1'b0; end
      else begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bin8 = 1'($urandom);
      end
      start8 = 1'b1;
      got = 1'b0;
      for (int j = 0; j < 30; j++) begin
        @(negedge clk);
        if (ready8) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) chk("t5_ready_timeout", 0, 1);
      @(posedge clk); #1;
      start8 = 1'b0;
      if ($urandom_range(0, 3) == 0) repeat (10) @(posedge clk);
    end

    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (q8.size() == 0 && !busy8) break;
    end
    chk("t5_drain8", q8.size(), 0);
    chk("drain4", q4.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
